// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the LEGv8 fetch stage
package fetch_pkg;
    localparam int INSTR_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [5:0] B_OPCODE = 6'b000101;
    localparam logic [7:0] CBZ_OPCODE = 8'b10110100;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} fetchState_t;
endpackage

// File: rtl/branch_predecode.sv
// branch_predecode: combinational B/CBZ detection and sign-extended word offset
module branch_predecode #(
    parameter logic [5:0] bOpcode = 6'b000101,
    parameter logic [7:0] cbzOpcode = 8'b10110100
) (
    input  logic [31:0] instr,
    output logic        isCbz,
    output logic        isB,
    output logic [31:0] offset
);
    // B carries imm26 at [25:0], CBZ carries imm19 at [23:5]; both are word offsets
    always_comb begin
        isB = instr[31:26] == bOpcode;
        isCbz = instr[31:24] == cbzOpcode;
        offset = isB ? {{6{instr[25]}}, instr[25:0]} :
                 isCbz ? {{13{instr[23]}}, instr[23:5]} : 32'd0;
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch at PC via req/ready handshake, capture and pre-decode the word
module instruction_fetch_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter logic [5:0] B_OPCODE = 6'b000101,
    parameter logic [7:0] CBZ_OPCODE = 8'b10110100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic        fetch_start,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic        busy,
    output logic        fetch_error,
    output logic        branchFlag,
    output logic        unconditionalBranchFlag,
    output logic [31:0] pcOffsetFilled
);
    import fetch_pkg::*;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

    fetchState_t state;
    logic [CW-1:0] waitCount;
    logic decCbz, decB;
    logic [INSTR_W-1:0] decOffset;

    branch_predecode #(.bOpcode(B_OPCODE), .cbzOpcode(CBZ_OPCODE)) predecode (
        .instr(mem_rdata),
        .isCbz(decCbz),
        .isB(decB),
        .offset(decOffset)
    );

    // fetch FSM; every output is a register so the PC block sees glitch-free values
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            waitCount <= '0;
            mem_addr <= '0;
            mem_req <= 1'b0;
            instruction <= '0;
            instr_valid <= 1'b0;
            busy <= 1'b0;
            fetch_error <= 1'b0;
            branchFlag <= 1'b0;
            unconditionalBranchFlag <= 1'b0;
            pcOffsetFilled <= '0;
        end else begin
            instr_valid <= 1'b0;
            case (state)
                IDLE: if (fetch_start) begin
                    busy <= 1'b1;
                    if (PC[1:0] == 2'b00) begin
                        mem_addr <= PC;
                        mem_req <= 1'b1;
                        fetch_error <= 1'b0;
                        waitCount <= '0;
                        state <= WAIT;
                    end else begin
                        fetch_error <= 1'b1;
                        instr_valid <= 1'b1;
                        state <= DONE;
                    end
                end
                WAIT: if (mem_ready) begin
                    instruction <= mem_rdata;
                    branchFlag <= decCbz;
                    unconditionalBranchFlag <= decB;
                    pcOffsetFilled <= decOffset;
                    mem_req <= 1'b0;
                    instr_valid <= 1'b1;
                    state <= DONE;
                end else if (waitCount == LAST_WAIT) begin
                    mem_req <= 1'b0;
                    fetch_error <= 1'b1;
                    instr_valid <= 1'b1;
                    state <= DONE;
                end else begin
                    waitCount <= waitCount + CW'(1);
                end
                DONE: begin
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scenarios for the fetch stage
module tb_instruction_fetch_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic fetch_start = 1'b0;
    logic mem_ready = 1'b0;
    logic [31:0] PC = '0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] mem_addr, instruction, pcOffsetFilled;
    logic mem_req, instr_valid, busy, fetch_error, branchFlag, unconditionalBranchFlag;
    int checks = 0;
    int errors = 0;
    int validCount, reqCycles, latency;
    logic finished, addrStable;

    instruction_fetch_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clock(clock),
        .reset(reset),
        .PC(PC),
        .fetch_start(fetch_start),
        .mem_addr(mem_addr),
        .mem_req(mem_req),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .busy(busy),
        .fetch_error(fetch_error),
        .branchFlag(branchFlag),
        .unconditionalBranchFlag(unconditionalBranchFlag),
        .pcOffsetFilled(pcOffsetFilled)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // one fetch; readyAfter = WAIT cycles before mem_ready (-1 never), pulseAt = WAIT cycle of a stray fetch_start
    task automatic run_fetch(input logic [31:0] pc, input int readyAfter, input logic [31:0] rdata, input int pulseAt);
        validCount = 0;
        reqCycles = 0;
        latency = -1;
        finished = 1'b0;
        addrStable = 1'b1;
        PC = pc;
        fetch_start = 1'b1;
        mem_ready = readyAfter == 0;
        mem_rdata = rdata;
        tick;
        fetch_start = 1'b0;
        for (int i = 0; i < 40 && !finished; i++) begin
            if (mem_req) begin
                reqCycles++;
                if (mem_addr !== pc) addrStable = 1'b0;
            end
            if (instr_valid) begin
                validCount++;
                if (latency < 0) latency = i + 1;
            end
            if (!busy) finished = 1'b1;
            else begin
                mem_ready = readyAfter >= 0 && i >= readyAfter;
                mem_rdata = mem_ready ? rdata : 32'hDEAD_BEEF;
                fetch_start = i == pulseAt;
                if (i == pulseAt) PC = 32'h200;
                tick;
                fetch_start = 1'b0;
            end
        end
        mem_ready = 1'b0;
        PC = pc;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        checks++;
        if ({mem_addr, instruction, pcOffsetFilled, mem_req, instr_valid, busy, fetch_error, branchFlag, unconditionalBranchFlag} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%h instr=%h off=%h req=%b v=%b busy=%b err=%b bf=%b ubf=%b, expected all zero",
                     mem_addr, instruction, pcOffsetFilled, mem_req, instr_valid, busy, fetch_error, branchFlag, unconditionalBranchFlag);
        end
        reset = 1'b0;
        tick;
        PC = 32'h40;
        fetch_start = 1'b1;
        tick;
        fetch_start = 1'b0;
        checks++;
        if ({mem_req, busy, mem_addr} !== {1'b1, 1'b1, 32'h40}) begin
            errors++;
            $display("FAIL reset_wait_entry: got req=%b busy=%b addr=%h, expected req=1 busy=1 addr=00000040", mem_req, busy, mem_addr);
        end
        tick;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({mem_addr, instruction, pcOffsetFilled, mem_req, instr_valid, busy, fetch_error, branchFlag, unconditionalBranchFlag} !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait: got addr=%h req=%b busy=%b err=%b, expected all zero before next edge", mem_addr, mem_req, busy, fetch_error);
        end
        reset = 1'b0;
        tick;
        tick;
        checks++;
        if ({mem_req, busy, instr_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: got req=%b busy=%b valid=%b, expected 000", mem_req, busy, instr_valid);
        end
    endtask

    task automatic test_b_decode;
        run_fetch(32'h100, 3, 32'h17FF_FFFE, -1);
        checks++;
        if ({finished, validCount, reqCycles, latency, addrStable} !== {1'b1, 32'd1, 32'd4, 32'd5, 1'b1}) begin
            errors++;
            $display("FAIL b_handshake: got done=%b valid=%0d req=%0d lat=%0d stable=%b, expected 1 1 4 5 1", finished, validCount, reqCycles, latency, addrStable);
        end
        checks++;
        if ({instruction, unconditionalBranchFlag, branchFlag, pcOffsetFilled, fetch_error} !== {32'h17FF_FFFE, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0}) begin
            errors++;
            $display("FAIL b_decode: got instr=%h ubf=%b bf=%b off=%h err=%b, expected 17fffffe 1 0 fffffffe 0",
                     instruction, unconditionalBranchFlag, branchFlag, pcOffsetFilled, fetch_error);
        end
    endtask

    task automatic test_cbz_decode;
        run_fetch(32'h104, 1, 32'hB400_0140, -1);
        checks++;
        if ({finished, validCount, instruction, branchFlag, unconditionalBranchFlag, pcOffsetFilled} !== {1'b1, 32'd1, 32'hB400_0140, 1'b1, 1'b0, 32'h0000_000A}) begin
            errors++;
            $display("FAIL cbz_decode: got done=%b valid=%0d instr=%h bf=%b ubf=%b off=%h, expected 1 1 b4000140 1 0 0000000a",
                     finished, validCount, instruction, branchFlag, unconditionalBranchFlag, pcOffsetFilled);
        end
        run_fetch(32'h108, 2, 32'h8B02_0020, -1);
        checks++;
        if ({finished, instruction, branchFlag, unconditionalBranchFlag, pcOffsetFilled} !== {1'b1, 32'h8B02_0020, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL plain_decode: got done=%b instr=%h bf=%b ubf=%b off=%h, expected 1 8b020020 0 0 00000000",
                     finished, instruction, branchFlag, unconditionalBranchFlag, pcOffsetFilled);
        end
    endtask

    task automatic test_zero_wait;
        run_fetch(32'h8, 0, 32'h8B02_0020, -1);
        checks++;
        if ({finished, latency, reqCycles, validCount, addrStable} !== {1'b1, 32'd2, 32'd1, 32'd1, 1'b1}) begin
            errors++;
            $display("FAIL zero_wait_timing: got done=%b lat=%0d req=%0d valid=%0d stable=%b, expected 1 2 1 1 1", finished, latency, reqCycles, validCount, addrStable);
        end
        checks++;
        if (mem_addr !== 32'h8) begin
            errors++;
            $display("FAIL zero_wait_addr: got %h, expected 00000008", mem_addr);
        end
    endtask

    task automatic test_timeout_misalign;
        run_fetch(32'h300, -1, 32'h0, -1);
        checks++;
        if ({finished, reqCycles, latency, validCount} !== {1'b1, 32'd16, 32'd17, 32'd1}) begin
            errors++;
            $display("FAIL timeout_timing: got done=%b req=%0d lat=%0d valid=%0d, expected 1 16 17 1", finished, reqCycles, latency, validCount);
        end
        checks++;
        if ({fetch_error, mem_req, instruction} !== {1'b1, 1'b0, 32'h8B02_0020}) begin
            errors++;
            $display("FAIL timeout_state: got err=%b req=%b instr=%h, expected 1 0 8b020020", fetch_error, mem_req, instruction);
        end
        run_fetch(32'h102, -1, 32'h0, -1);
        checks++;
        if ({finished, reqCycles, validCount, fetch_error} !== {1'b1, 32'd0, 32'd1, 1'b1}) begin
            errors++;
            $display("FAIL misaligned: got done=%b req=%0d valid=%0d err=%b, expected 1 0 1 1", finished, reqCycles, validCount, fetch_error);
        end
        checks++;
        if ({instruction, branchFlag, unconditionalBranchFlag, pcOffsetFilled} !== {32'h8B02_0020, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL misaligned_hold: got instr=%h bf=%b ubf=%b off=%h, expected 8b020020 0 0 00000000",
                     instruction, branchFlag, unconditionalBranchFlag, pcOffsetFilled);
        end
    endtask

    task automatic test_ignored_request;
        run_fetch(32'h400, 2, 32'h17FF_FFFE, 1);
        checks++;
        if ({finished, reqCycles, validCount, addrStable} !== {1'b1, 32'd3, 32'd1, 1'b1}) begin
            errors++;
            $display("FAIL ignored_request: got done=%b req=%0d valid=%0d stable=%b, expected 1 3 1 1", finished, reqCycles, validCount, addrStable);
        end
        checks++;
        if ({fetch_error, instruction, unconditionalBranchFlag} !== {1'b0, 32'h17FF_FFFE, 1'b1}) begin
            errors++;
            $display("FAIL error_cleared: got err=%b instr=%h ubf=%b, expected 0 17fffffe 1", fetch_error, instruction, unconditionalBranchFlag);
        end
        tick;
        tick;
        checks++;
        if ({busy, mem_req, instr_valid} !== 3'b000) begin
            errors++;
            $display("FAIL not_queued: got busy=%b req=%b valid=%b, expected 000", busy, mem_req, instr_valid);
        end
    endtask

    initial begin
        test_reset;
        test_b_decode;
        test_cbz_decode;
        test_zero_wait;
        test_timeout_misalign;
        test_ignored_request;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage of the multi-cycle LEGv8 datapath. It sits between the PC block and instruction memory.
- On a fetch request it reads the word at the current PC through a req/ready memory handshake and latches it into an instruction register.
- It pre-decodes B and CBZ to drive the PC block's branchFlag, unconditionalBranchFlag and pcOffsetFilled inputs.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in WAIT before fetch_error is raised
B_OPCODE, 6'b000101, instruction[31:26] value for unconditional branch
CBZ_OPCODE, 8'b10110100, instruction[31:24] value for compare-and-branch-on-zero

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
PC  input  32  current program counter (byte address)
fetch_start  input  1  single-cycle request from controller to fetch at PC
mem_addr  output  32  instruction memory address
mem_req  output  1  memory read request, held until accepted
mem_ready  input  1  memory has valid mem_rdata this cycle
mem_rdata  input  32  instruction word from memory
instruction  output  32  instruction register
instr_valid  output  1  one-cycle pulse: new instruction and decode outputs valid
busy  output  1  high in any state other than IDLE
fetch_error  output  1  sticky until next accepted fetch_start: misaligned PC or timeout
branchFlag  output  1  instruction is CBZ
unconditionalBranchFlag  output  1  instruction is B
pcOffsetFilled  output  32  sign-extended word offset for the PC block

Behaviour:
- Reset (async, any state): state=IDLE. All outputs are 0: mem_addr, mem_req, instruction, instr_valid, busy, fetch_error, flags, pcOffsetFilled. Timeout counter is cleared.
- States: IDLE, WAIT, DONE.
- IDLE:
  - fetch_start=1 with PC[1:0]==0: latch mem_addr=PC, set mem_req=1, clear fetch_error, clear counter, go to WAIT.
  - fetch_start=1 with PC[1:0]!=0: set fetch_error=1. Leave instruction, flags and offset unchanged. Go to DONE. No memory request is issued.
- WAIT:
  - mem_req stays 1 and mem_addr stays stable.
  - mem_ready=1: latch instruction=mem_rdata, load decode outputs, mem_req=0, go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without mem_ready: mem_req=0, fetch_error=1, instruction unchanged, go to DONE.
- DONE: instr_valid=1 for exactly this one cycle, then go to IDLE. instr_valid is asserted for error completions too; the controller checks fetch_error.
- fetch_start while busy is ignored and not queued.
- Latency: fetch_start sampled at edge 0 → mem_req high after edge 0. mem_ready sampled at edge k → instruction valid and instr_valid high after edge k. Minimum is 2 cycles from fetch_start to instr_valid (mem_ready high in the first WAIT cycle).
- Decode, registered together with instruction:
  - [31:26]==B_OPCODE: unconditionalBranchFlag=1, branchFlag=0, pcOffsetFilled=sign-extend instruction[25:0].
  - [31:24]==CBZ_OPCODE: branchFlag=1, unconditionalBranchFlag=0, pcOffsetFilled=sign-extend instruction[23:5].
  - Otherwise both flags are 0 and pcOffsetFilled=0.
- The offset is in words, unscaled; the PC block shifts it left by 2.
- instruction, flags and pcOffsetFilled hold until the next successful capture.
- mem_rdata is ignored outside WAIT.

Decomposition:
- Shared package fetch_pkg:
  - state enum {IDLE, WAIT, DONE}
  - B_OPCODE and CBZ_OPCODE constants
  - widths INSTR_W=32, ADDR_W=32
- One sub-module: branch_predecode. Purely combinational: instruction word → flags and sign-extended offset. It is instantiated before the capture register, so the decode logic can be reused by later decode stages.

Test Plan:
1. Reset mid-WAIT: fetch_start at PC=0x40, assert reset before mem_ready → mem_req drops immediately (async); all outputs 0; state IDLE.
2. B decode: PC=0x100, mem_ready after 3 WAIT cycles, rdata=0x17FFFFFE → instruction=0x17FFFFFE, unconditionalBranchFlag=1, branchFlag=0, pcOffsetFilled=0xFFFFFFFE; instr_valid is a single-cycle pulse.
3. CBZ decode: rdata=0xB4000140 (imm19=10) → branchFlag=1, unconditionalBranchFlag=0, pcOffsetFilled=0x0000000A. Then non-branch rdata=0x8B020020 → both flags 0, pcOffsetFilled=0.
4. Zero-wait memory: mem_ready held high continuously, fetch_start at PC=0x8 → mem_addr=0x8, instr_valid exactly 2 cycles after fetch_start; mem_req high for 1 cycle.
5. Timeout and misalignment: mem_ready never asserted → fetch_error=1 and instr_valid pulse after TIMEOUT_CYCLES WAIT cycles; mem_req deasserted. Then PC=0x102 → fetch_error=1 with no mem_req.
6. Ignored request: second fetch_start pulsed during WAIT → no extra mem_req cycle and exactly one instr_valid. A following valid fetch clears fetch_error.
